bilinear_fetch_ctrl: RTL and testbench

- Sequences the 2x bilinear upscale path: converts a stream of VGA raster coordinates (DST = 2*SRC) into the four neighbouring source pixels plus sub-pixel flags consumed by Bilinear_Upscaler.
- Owns three source-line buffers (ring of top/bottom/fill) and a single-read-port fetch engine into the QVGA frame buffer. It prefetches the next source row while the current row pair is displayed.
- Sits between the VGA decoder / frame buffer and Bilinear_Upscaler.

---
 rtl/bilinear_fetch_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_bilinear_fetch_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bilinear_fetch_ctrl.sv
// Fetch/line-buffer controller for the 2x bilinear upscaler. It keeps a ring of three source
// lines and turns VGA raster coordinates into the four neighbour pixels plus sub-pixel flags.
module bilinear_fetch_ctrl #(
  parameter int SRC_W  = 320,
  parameter int SRC_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              display_en,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [11:0]       fb_rd_data,
  output logic [11:0]       p_tl,
  output logic [11:0]       p_tr,
  output logic [11:0]       p_bl,
  output logic [11:0]       p_br,
  output logic              x_is_odd,
  output logic              y_is_odd,
  output logic              pix_valid,
  output logic              underrun
);
  localparam int CW = $clog2(SRC_W);
  localparam int RW = $clog2(SRC_H);

  typedef enum logic [1:0] {F_IDLE, F_PRE0, F_PRE1, F_LINE} fstate_t;

  logic [11:0] lbuf [0:2][0:SRC_W-1];

  fstate_t           state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     fetch_row_q, fetch_row_d, line_row_q, line_row_d;
  logic              pending_q, pending_d;
  logic [1:0]        top_sel_q, top_sel_d, bot_sel_q, bot_sel_d, fill_sel_q, fill_sel_d;
  logic              fill_ready_q, fill_ready_d, underrun_q, underrun_d;
  logic              fb_rd_en_q, fb_rd_en_d;
  logic [ADDR_W-1:0] fb_rd_addr_q, fb_rd_addr_d;
  logic [CW-1:0]     rd_col_q, rd_col_d, wr_col_q, wr_col_d;
  logic [1:0]        rd_buf_q, rd_buf_d, wr_buf_q, wr_buf_d;
  logic              rd_line_q, rd_line_d, rd_last_q, rd_last_d;
  logic              wr_en_q, wr_en_d, wr_line_q, wr_line_d, wr_last_q, wr_last_d;
  logic [CW-1:0]     sx_q, sx_d, sx1_q, sx1_d;
  logic              x_odd_s1_q, x_odd_s1_d, y_odd_s1_q, y_odd_s1_d, de_s1_q, de_s1_d;
  logic [11:0]       p_tl_q, p_tl_d, p_tr_q, p_tr_d, p_bl_q, p_bl_d, p_br_q, p_br_d;
  logic              x_is_odd_q, y_is_odd_q, pix_valid_q;

  logic          line_event, wr_kill;
  logic [9:0]    row_calc;
  logic [RW-1:0] line_row;

  assign line_event = display_en && (x_pixel == 10'd0) && !y_pixel[0];
  assign row_calc   = {1'b0, y_pixel[9:1]} + 10'd2;
  assign line_row   = (row_calc > 10'(SRC_H - 1)) ? RW'(SRC_H - 1) : RW'(row_calc);
  // Returns already in flight are dropped when their fetch is cancelled.
  assign wr_kill    = frame_start || (line_event && wr_line_q);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    fetch_row_d  = fetch_row_q;
    line_row_d   = line_row_q;
    pending_d    = pending_q;
    top_sel_d    = top_sel_q;
    bot_sel_d    = bot_sel_q;
    fill_sel_d   = fill_sel_q;
    fill_ready_d = fill_ready_q;
    underrun_d   = underrun_q;
    fb_rd_en_d   = 1'b0;
    fb_rd_addr_d = fb_rd_addr_q;
    rd_col_d     = rd_col_q;
    rd_buf_d     = rd_buf_q;
    rd_line_d    = 1'b0;
    rd_last_d    = 1'b0;
    wr_en_d      = fb_rd_en_q;
    wr_col_d     = rd_col_q;
    wr_buf_d     = rd_buf_q;
    wr_line_d    = rd_line_q;
    wr_last_d    = rd_last_q;

    case (state_q)
      F_PRE0, F_PRE1, F_LINE: begin
        fb_rd_en_d   = 1'b1;
        fb_rd_addr_d = ADDR_W'(fetch_row_q) * ADDR_W'(SRC_W) + ADDR_W'(col_q);
        rd_col_d     = col_q;
        rd_buf_d     = (state_q == F_PRE0) ? top_sel_q :
                       (state_q == F_PRE1) ? bot_sel_q : fill_sel_q;
        rd_line_d    = (state_q == F_LINE);
        rd_last_d    = (col_q == CW'(SRC_W - 1));
        col_d        = col_q + 1'b1;
        if (col_q == CW'(SRC_W - 1)) begin
          col_d = '0;
          if (state_q == F_PRE0) begin
            state_d     = F_PRE1;
            fetch_row_d = RW'(1);
          end else begin
            state_d = F_IDLE;
          end
        end
      end
      default: begin
        if (pending_q) begin
          state_d     = F_LINE;
          fetch_row_d = line_row_q;
          col_d       = '0;
          pending_d   = 1'b0;
        end
      end
    endcase

    if (wr_en_q && wr_last_q && wr_line_q)
      fill_ready_d = 1'b1;

    if (line_event) begin
      fill_ready_d = 1'b0;
      if (y_pixel != 10'd0) begin
        top_sel_d  = bot_sel_q;
        bot_sel_d  = fill_sel_q;
        fill_sel_d = top_sel_q;
        if (!fill_ready_q)
          underrun_d = 1'b1;
      end
      // Preload is never interrupted; the line fetch waits for it to finish.
      if (state_q == F_PRE0 || state_q == F_PRE1) begin
        pending_d  = 1'b1;
        line_row_d = line_row;
      end else begin
        state_d     = F_LINE;
        fetch_row_d = line_row;
        col_d       = '0;
        pending_d   = 1'b0;
        fb_rd_en_d  = 1'b0;
      end
      if (rd_line_q)
        wr_en_d = 1'b0;
    end

    if (frame_start) begin
      state_d      = F_PRE0;
      col_d        = '0;
      fetch_row_d  = '0;
      pending_d    = 1'b0;
      top_sel_d    = 2'd0;
      bot_sel_d    = 2'd1;
      fill_sel_d   = 2'd2;
      fill_ready_d = 1'b0;
      underrun_d   = 1'b0;
      fb_rd_en_d   = 1'b0;
      wr_en_d      = 1'b0;
    end
  end

  always_comb begin
    sx_d       = CW'(x_pixel >> 1);
    sx1_d      = (sx_d == CW'(SRC_W - 1)) ? sx_d : sx_d + 1'b1;
    x_odd_s1_d = x_pixel[0];
    y_odd_s1_d = y_pixel[0];
    de_s1_d    = display_en;
    p_tl_d     = 12'h000;
    p_tr_d     = 12'h000;
    p_bl_d     = 12'h000;
    p_br_d     = 12'h000;
    if (de_s1_q) begin
      p_tl_d = lbuf[top_sel_q][sx_q];
      p_tr_d = lbuf[top_sel_q][sx1_q];
      p_bl_d = lbuf[bot_sel_q][sx_q];
      p_br_d = lbuf[bot_sel_q][sx1_q];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_q && !wr_kill)
      lbuf[wr_buf_q][wr_col_q] <= fb_rd_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= F_IDLE;
      col_q        <= '0;
      fetch_row_q  <= '0;
      line_row_q   <= '0;
      pending_q    <= 1'b0;
      top_sel_q    <= 2'd0;
      bot_sel_q    <= 2'd1;
      fill_sel_q   <= 2'd2;
      fill_ready_q <= 1'b0;
      underrun_q   <= 1'b0;
      fb_rd_en_q   <= 1'b0;
      fb_rd_addr_q <= '0;
      rd_col_q     <= '0;
      rd_buf_q     <= '0;
      rd_line_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_col_q     <= '0;
      wr_buf_q     <= '0;
      wr_line_q    <= 1'b0;
      wr_last_q    <= 1'b0;
      sx_q         <= '0;
      sx1_q        <= '0;
      x_odd_s1_q   <= 1'b0;
      y_odd_s1_q   <= 1'b0;
      de_s1_q      <= 1'b0;
      p_tl_q       <= '0;
      p_tr_q       <= '0;
      p_bl_q       <= '0;
      p_br_q       <= '0;
      x_is_odd_q   <= 1'b0;
      y_is_odd_q   <= 1'b0;
      pix_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      fetch_row_q  <= fetch_row_d;
      line_row_q   <= line_row_d;
      pending_q    <= pending_d;
      top_sel_q    <= top_sel_d;
      bot_sel_q    <= bot_sel_d;
      fill_sel_q   <= fill_sel_d;
      fill_ready_q <= fill_ready_d;
      underrun_q   <= underrun_d;
      fb_rd_en_q   <= fb_rd_en_d;
      fb_rd_addr_q <= fb_rd_addr_d;
      rd_col_q     <= rd_col_d;
      rd_buf_q     <= rd_buf_d;
      rd_line_q    <= rd_line_d;
      rd_last_q    <= rd_last_d;
      wr_en_q      <= wr_en_d;
      wr_col_q     <= wr_col_d;
      wr_buf_q     <= wr_buf_d;
      wr_line_q    <= wr_line_d;
      wr_last_q    <= wr_last_d;
      sx_q         <= sx_d;
      sx1_q        <= sx1_d;
      x_odd_s1_q   <= x_odd_s1_d;
      y_odd_s1_q   <= y_odd_s1_d;
      de_s1_q      <= de_s1_d;
      p_tl_q       <= p_tl_d;
      p_tr_q       <= p_tr_d;
      p_bl_q       <= p_bl_d;
      p_br_q       <= p_br_d;
      x_is_odd_q   <= x_odd_s1_q;
      y_is_odd_q   <= y_odd_s1_q;
      pix_valid_q  <= de_s1_q;
    end
  end

  assign fb_rd_en   = fb_rd_en_q;
  assign fb_rd_addr = fb_rd_addr_q;
  assign p_tl       = p_tl_q;
  assign p_tr       = p_tr_q;
  assign p_bl       = p_bl_q;
  assign p_br       = p_br_q;
  assign x_is_odd   = x_is_odd_q;
  assign y_is_odd   = y_is_odd_q;
  assign pix_valid  = pix_valid_q;
  assign underrun   = underrun_q;
endmodule

// File: tb/tb_bilinear_fetch_ctrl.sv
// Directed bench for bilinear_fetch_ctrl: frame buffer model holds pixel(r,c) = {r[3:0],c[3:0],4'h5}
// and every neighbour/flag value below is worked out by hand from that pattern.
module tb_bilinear_fetch_ctrl;
  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              display_en = 1'b0;
  logic [9:0]        x_pixel = '0;
  logic [9:0]        y_pixel = '0;
  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_rd_addr;
  logic [11:0]       fb_rd_data = '0;
  logic [11:0]       p_tl, p_tr, p_bl, p_br;
  logic              x_is_odd, y_is_odd, pix_valid, underrun;

  int checks = 0;
  int errors = 0;
  int rd_log[$];
  bit mon_en = 1'b0;
  bit nz_seen = 1'b0;

  bilinear_fetch_ctrl #(.SRC_W(320), .SRC_H(240), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .display_en(display_en),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr),
    .fb_rd_data(fb_rd_data), .p_tl(p_tl), .p_tr(p_tr), .p_bl(p_bl), .p_br(p_br),
    .x_is_odd(x_is_odd), .y_is_odd(y_is_odd), .pix_valid(pix_valid), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pix_of(input logic [ADDR_W-1:0] a);
    logic [31:0] r, c;
    r = 32'(a) / 320;
    c = 32'(a) % 320;
    return {r[3:0], c[3:0], 4'h5};
  endfunction

  // Frame buffer model: one-cycle read latency, and a log of every issued address.
  always @(posedge clk) begin
    if (fb_rd_en) begin
      rd_log.push_back(int'(fb_rd_addr));
      fb_rd_data <= pix_of(fb_rd_addr);
    end
  end

  always @(negedge clk) begin
    if (mon_en && (fb_rd_en || (|{p_tl, p_tr, p_bl, p_br, x_is_odd, y_is_odd, pix_valid, underrun})))
      nz_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one active pixel, then returns once its outputs have emerged (latency 2).
  task automatic pix(input int x, input int y);
    @(posedge clk); #1;
    display_en = 1'b1;
    x_pixel = 10'(x);
    y_pixel = 10'(y);
    @(posedge clk); #1;
    display_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_frame_start();
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  function automatic int first_gap(input int from, input int to);
    for (int i = from; i <= to; i++)
      if (i >= rd_log.size() || rd_log[i] != i) return i;
    return -1;
  endfunction

  initial begin
    tick(5);
    chk("rst_outs", {p_tl, p_tr, p_bl, p_br, x_is_odd, y_is_odd, pix_valid, underrun, fb_rd_en}, 64'd0);
    chk("rst_addr", 64'(fb_rd_addr), 64'd0);
    reset_n = 1'b1;
    mon_en = 1'b1;
    tick(1000);
    mon_en = 1'b0;
    chk("idle_reads", 64'(rd_log.size()), 64'd0);
    chk("idle_outs", 64'(nz_seen), 64'd0);

    // Preload rows 0 and 1
    pulse_frame_start();
    tick(700);
    chk("pre_count", 64'(rd_log.size()), 64'd640);
    chk("pre_seq", 64'(first_gap(0, 639)), 64'(-1));

    // Output line 0
    pix(0, 0);
    chk("l0x0_tl", 64'(p_tl), 64'h005);
    chk("l0x0_tr", 64'(p_tr), 64'h015);
    chk("l0x0_bl", 64'(p_bl), 64'h105);
    chk("l0x0_br", 64'(p_br), 64'h115);
    chk("l0x0_flags", {x_is_odd, y_is_odd, pix_valid}, 64'b001);
    pix(1, 0);
    chk("l0x1_tl", 64'(p_tl), 64'h005);
    chk("l0x1_br", 64'(p_br), 64'h115);
    chk("l0x1_xodd", 64'(x_is_odd), 64'd1);
    pix(2, 0);
    chk("l0x2_tl", 64'(p_tl), 64'h015);
    chk("l0x2_tr", 64'(p_tr), 64'h025);
    chk("l0x2_bl", 64'(p_bl), 64'h115);
    chk("l0x2_br", 64'(p_br), 64'h125);
    chk("l0x2_xodd", 64'(x_is_odd), 64'd0);
    pix(3, 0);
    chk("l0x3_xodd", 64'(x_is_odd), 64'd1);
    chk("l0x3_tr", 64'(p_tr), 64'h025);
    tick(1);
    chk("blank_valid", 64'(pix_valid), 64'd0);
    chk("blank_tl", 64'(p_tl), 64'h000);
    pix(639, 0);
    chk("l0x639_tl", 64'(p_tl), 64'h0F5);
    chk("l0x639_tr", 64'(p_tr), 64'h0F5);
    chk("l0x639_bl", 64'(p_bl), 64'h1F5);
    chk("l0x639_br", 64'(p_br), 64'h1F5);

    // Row 2 fetched into the fill buffer
    tick(400);
    chk("row2_count", 64'(rd_log.size()), 64'd960);
    chk("row2_seq", 64'(first_gap(640, 959)), 64'(-1));
    chk("row2_underrun", 64'(underrun), 64'd0);

    // Line y=2 rotates: rows 1/2 on display
    pix(0, 2);
    chk("l2x0_tl", 64'(p_tl), 64'h105);
    chk("l2x0_tr", 64'(p_tr), 64'h115);
    chk("l2x0_bl", 64'(p_bl), 64'h205);
    chk("l2x0_br", 64'(p_br), 64'h215);
    chk("l2_underrun", 64'(underrun), 64'd0);
    pix(2, 3);
    chk("l3x2_yodd", 64'(y_is_odd), 64'd1);
    chk("l3x2_tl", 64'(p_tl), 64'h115);
    tick(400);

    // Line y=6 arrives while row 4 is still being fetched
    pix(0, 4);
    chk("l4x0_tl", 64'(p_tl), 64'h205);
    chk("l4x0_bl", 64'(p_bl), 64'h305);
    chk("l4_underrun", 64'(underrun), 64'd0);
    tick(97);
    pix(0, 6);
    chk("l6_underrun", 64'(underrun), 64'd1);
    chk("l6x0_tl", 64'(p_tl), 64'h305);
    tick(500);
    chk("underrun_held", 64'(underrun), 64'd1);

    // New frame clears underrun and restarts preload at address 0
    rd_log.delete();
    pulse_frame_start();
    tick(2);
    chk("fs_clears_underrun", 64'(underrun), 64'd0);
    tick(700);
    chk("fs2_count", 64'(rd_log.size()), 64'd640);
    chk("fs2_first", 64'(rd_log[0]), 64'd0);

    // Bottom clamp: rows 239 on both top and bottom at y=478
    pix(0, 474);
    tick(400);
    pix(0, 476);
    tick(400);
    chk("row239_last_addr", 64'(rd_log[rd_log.size()-1]), 64'd76799);
    pix(0, 478);
    chk("l478_tl", 64'(p_tl), 64'hF05);
    chk("l478_bl", 64'(p_bl), 64'hF05);
    chk("l478_tr", 64'(p_tr), 64'hF15);
    chk("l478_br", 64'(p_br), 64'hF15);
    pix(639, 479);
    chk("l479x639_tr", 64'(p_tr), 64'hFF5);
    chk("l479x639_br", 64'(p_br), 64'hFF5);

    // Mid-frame reset during preload
    pulse_frame_start();
    tick(100);
    reset_n = 1'b0;
    tick(2);
    chk("midrst_rd_en", 64'(fb_rd_en), 64'd0);
    reset_n = 1'b1;
    rd_log.delete();
    tick(500);
    chk("midrst_reads", 64'(rd_log.size()), 64'd0);
    chk("midrst_underrun", 64'(underrun), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
